imem_fetch_buf: RTL and testbench

//  Parametrised instruction memory with registered read, valid/ready request and response

---
 rtl/imem_fetch_buf.sv | 148 ++++++++++++++
 tb/tb_imem_fetch_buf.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_buf.sv
// imem_fetch_buf
//   Instruction memory with a registered read and valid/ready request and
//   response channels. Each accepted fetch is decoded (alignment and range),
//   read from memory and written straight into a BUF_DEPTH-entry response
//   FIFO. The FIFO absorbs back-pressure from decode. Faulting fetches return
//   NOP together with a precise exception code and the faulting PC.
//
// Ports
//   clk, rst         clock and synchronous active-high reset
//   flush            drop every buffered response and refuse requests this cycle
//   req_valid/ready  fetch request handshake, req_pc is the byte address
//   rsp_valid/ready  response handshake on the FIFO head
//   rsp_pc           PC of the head response
//   rsp_instr        instruction word, NOP on fault or when the FIFO is empty
//   rsp_exc_en       head response carries a fault
//   rsp_exc_code     0 = misaligned, 1 = access fault
//   rsp_exc_val      faulting PC when rsp_exc_en, else 0
//   fault_count      saturating count of faulting responses pushed
module imem_fetch_buf #(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter string       INIT_FILE = "",
  parameter int unsigned BUF_DEPTH = 2,
  parameter logic [31:0] NOP       = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_pc,
  output logic [31:0] rsp_instr,
  output logic        rsp_exc_en,
  output logic [3:0]  rsp_exc_code,
  output logic [63:0] rsp_exc_val,
  output logic [15:0] fault_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [31:0] mem_q [DEPTH];

  logic [63:0] pc_q    [BUF_DEPTH];
  logic [31:0] instr_q [BUF_DEPTH];
  logic        en_q    [BUF_DEPTH];
  logic [3:0]  code_q  [BUF_DEPTH];
  logic [63:0] val_q   [BUF_DEPTH];

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   fault_count_q, fault_count_d;

  logic [61:0] word_off;
  logic        misaligned, out_of_range, fault;
  logic [31:0] rd_instr;
  logic [3:0]  rd_code;
  logic [63:0] rd_val;
  logic        full, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Word offset from the full 64-bit difference, so an address below
  // BASE_ADDR can never alias back into the array.
  assign word_off     = 62'((req_pc - BASE_ADDR) >> 2);
  assign misaligned   = (req_pc[1:0] != 2'b00);
  assign out_of_range = (req_pc < BASE_ADDR) || (word_off >= 62'(DEPTH));
  assign fault        = misaligned || out_of_range;

  // Misalignment wins over the range check when both apply.
  always_comb begin
    rd_instr = NOP;
    rd_code  = 4'd0;
    rd_val   = 64'd0;
    if (misaligned) begin
      rd_val = req_pc;
    end else if (out_of_range) begin
      rd_code = 4'd1;
      rd_val  = req_pc;
    end else begin
      rd_instr = mem_q[word_off[AW-1:0]];
    end
  end

  assign full      = (count_q == CW'(BUF_DEPTH));
  assign rsp_valid = (count_q != '0);
  // A full FIFO can still accept when the head leaves on the same edge.
  assign req_ready = !rst && !flush && (!full || (rsp_valid && rsp_ready));
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready && !flush && !rst;

  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    fault_count_d = fault_count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = ptr_inc(tail_q);
      if (pop)  head_d = ptr_inc(head_q);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
    end
    if (push && fault && (fault_count_q != 16'hFFFF)) fault_count_d = fault_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      fault_count_q <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      fault_count_q <= fault_count_d;
    end
  end

  // Entry payload needs no reset: an empty FIFO masks the head fields below.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail_q]    <= req_pc;
      instr_q[tail_q] <= rd_instr;
      en_q[tail_q]    <= fault;
      code_q[tail_q]  <= rd_code;
      val_q[tail_q]   <= rd_val;
    end
  end

  assign rsp_pc       = rsp_valid ? pc_q[head_q]    : 64'd0;
  assign rsp_instr    = rsp_valid ? instr_q[head_q] : NOP;
  assign rsp_exc_en   = rsp_valid ? en_q[head_q]    : 1'b0;
  assign rsp_exc_code = rsp_valid ? code_q[head_q]  : 4'd0;
  assign rsp_exc_val  = rsp_valid ? val_q[head_q]   : 64'd0;
  assign fault_count  = fault_count_q;

endmodule

// File: tb/tb_imem_fetch_buf.sv
// Testbench for imem_fetch_buf.
//   dut0 uses BASE_ADDR 0, dut1 uses BASE_ADDR 0x8000_0000; both have
//   BUF_DEPTH 2 and DEPTH 4096. Expected responses are queued when a request
//   is issued and popped by per-DUT monitors on each response handshake.
module tb_imem_fetch_buf;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] IA  = 32'hAAAA0001;
  localparam logic [31:0] IB  = 32'hAAAA0002;
  localparam logic [31:0] IC  = 32'hAAAA0003;
  localparam logic [31:0] ID  = 32'hAAAA0004;
  localparam logic [31:0] IE  = 32'hEEEE0FFF;
  localparam logic [31:0] IF1 = 32'h12345678;
  localparam logic [31:0] IG1 = 32'h9ABC0FFF;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        en;
    logic [3:0]  code;
    logic [63:0] val;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush0, req_valid0, req_ready0, rsp_valid0, rsp_ready0, exc_en0;
  logic [63:0] req_pc0, rsp_pc0, exc_val0;
  logic [31:0] instr0;
  logic [3:0]  exc_code0;
  logic [15:0] fault_count0;
  logic        flush1, req_valid1, req_ready1, rsp_valid1, rsp_ready1, exc_en1;
  logic [63:0] req_pc1, rsp_pc1, exc_val1;
  logic [31:0] instr1;
  logic [3:0]  exc_code1;
  logic [15:0] fault_count1;

  int errors = 0;
  int checks = 0;
  rsp_t exp0[$];
  rsp_t exp1[$];

  imem_fetch_buf #(.DEPTH(4096), .BASE_ADDR(64'h0), .BUF_DEPTH(2)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_pc(req_pc0), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_pc(rsp_pc0),
    .rsp_instr(instr0), .rsp_exc_en(exc_en0), .rsp_exc_code(exc_code0),
    .rsp_exc_val(exc_val0), .fault_count(fault_count0)
  );

  imem_fetch_buf #(.DEPTH(4096), .BASE_ADDR(64'h8000_0000), .BUF_DEPTH(2)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_pc(req_pc1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_pc(rsp_pc1),
    .rsp_instr(instr1), .rsp_exc_en(exc_en1), .rsp_exc_code(exc_code1),
    .rsp_exc_val(exc_val1), .fault_count(fault_count1)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic rsp_t ok(input logic [63:0] pc, input logic [31:0] ins);
    rsp_t r;
    r.pc = pc; r.instr = ins; r.en = 1'b0; r.code = 4'd0; r.val = 64'd0;
    return r;
  endfunction

  function automatic rsp_t flt(input logic [63:0] pc, input logic [3:0] code);
    rsp_t r;
    r.pc = pc; r.instr = NOP; r.en = 1'b1; r.code = code; r.val = pc;
    return r;
  endfunction

  function automatic rsp_t none();
    return '0;
  endfunction

  // One clock cycle of stimulus on the selected DUT; entered and left #1 after a posedge.
  task automatic applyStimulus(input int port, input logic r, input logic fl, input logic v,
                               input logic [63:0] pc, input logic rdy, input logic expReady,
                               input int expValid, input rsp_t e);
    rst = r;
    if (port == 0) begin
      flush0 = fl; req_valid0 = v; req_pc0 = pc; rsp_ready0 = rdy;
    end else begin
      flush1 = fl; req_valid1 = v; req_pc1 = pc; rsp_ready1 = rdy;
    end
    @(negedge clk);
    if (port == 0) begin
      checkOutput("dut0 req_ready", 64'(req_ready0), 64'(expReady));
      if (expValid >= 0) checkOutput("dut0 rsp_valid", 64'(rsp_valid0), 64'(expValid[0]));
      if (v && expReady) exp0.push_back(e);
    end else begin
      checkOutput("dut1 req_ready", 64'(req_ready1), 64'(expReady));
      if (expValid >= 0) checkOutput("dut1 rsp_valid", 64'(rsp_valid1), 64'(expValid[0]));
      if (v && expReady) exp1.push_back(e);
    end
    @(posedge clk);
    #1;
    if (fl || r) begin
      if (port == 0) exp0.delete();
      else exp1.delete();
    end
  endtask

  // Scoreboard monitors: compare the head on every completed response handshake.
  always @(negedge clk) begin
    if (!rst && !flush0 && rsp_valid0 && rsp_ready0) begin
      if (exp0.size() == 0) begin
        checkOutput("dut0 unexpected response", 64'd1, 64'd0);
      end else begin
        rsp_t e;
        e = exp0.pop_front();
        checkOutput("dut0 rsp_pc", rsp_pc0, e.pc);
        checkOutput("dut0 rsp_instr", 64'(instr0), 64'(e.instr));
        checkOutput("dut0 rsp_exc_en", 64'(exc_en0), 64'(e.en));
        checkOutput("dut0 rsp_exc_code", 64'(exc_code0), 64'(e.code));
        checkOutput("dut0 rsp_exc_val", exc_val0, e.val);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && !flush1 && rsp_valid1 && rsp_ready1) begin
      if (exp1.size() == 0) begin
        checkOutput("dut1 unexpected response", 64'd1, 64'd0);
      end else begin
        rsp_t e;
        e = exp1.pop_front();
        checkOutput("dut1 rsp_pc", rsp_pc1, e.pc);
        checkOutput("dut1 rsp_instr", 64'(instr1), 64'(e.instr));
        checkOutput("dut1 rsp_exc_en", 64'(exc_en1), 64'(e.en));
        checkOutput("dut1 rsp_exc_code", 64'(exc_code1), 64'(e.code));
        checkOutput("dut1 rsp_exc_val", exc_val1, e.val);
      end
    end
  end

  initial begin
    rst = 1'b1;
    flush0 = 1'b0; req_valid0 = 1'b0; req_pc0 = 64'd0; rsp_ready0 = 1'b0;
    flush1 = 1'b0; req_valid1 = 1'b0; req_pc1 = 64'd0; rsp_ready1 = 1'b0;
    dut0.mem_q[0] = IA;
    dut0.mem_q[1] = IB;
    dut0.mem_q[2] = IC;
    dut0.mem_q[3] = ID;
    dut0.mem_q[4095] = IE;
    dut1.mem_q[0] = IF1;
    dut1.mem_q[4095] = IG1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset req_ready", 64'(req_ready0), 64'd0);
    checkOutput("reset rsp_valid", 64'(rsp_valid0), 64'd0);
    checkOutput("reset rsp_instr", 64'(instr0), 64'(NOP));
    checkOutput("reset rsp_pc", rsp_pc0, 64'd0);
    checkOutput("reset exc_en", 64'(exc_en0), 64'd0);
    checkOutput("reset fault_count", 64'(fault_count0), 64'd0);
    @(posedge clk);
    #1;

    // T1 streaming, one response per cycle
    applyStimulus(0, 0, 0, 1, 64'h0, 1, 1, 0, ok(64'h0, IA));
    applyStimulus(0, 0, 0, 1, 64'h4, 1, 1, 1, ok(64'h4, IB));
    applyStimulus(0, 0, 0, 1, 64'h8, 1, 1, 1, ok(64'h8, IC));
    applyStimulus(0, 0, 0, 1, 64'hC, 1, 1, 1, ok(64'hC, ID));
    applyStimulus(0, 0, 0, 0, 64'h0, 1, 1, 1, none());
    applyStimulus(0, 0, 0, 0, 64'h0, 1, 1, 0, none());

    // T2 back-pressure, simultaneous push/pop while full
    applyStimulus(0, 0, 0, 1, 64'h0, 0, 1, 0, ok(64'h0, IA));
    applyStimulus(0, 0, 0, 1, 64'h4, 0, 1, 1, ok(64'h4, IB));
    applyStimulus(0, 0, 0, 1, 64'h8, 0, 0, 1, none());
    applyStimulus(0, 0, 0, 1, 64'h8, 1, 1, 1, ok(64'h8, IC));
    applyStimulus(0, 0, 0, 0, 64'h0, 0, 0, 1, none());
    applyStimulus(0, 0, 0, 0, 64'h0, 1, 1, 1, none());
    applyStimulus(0, 0, 0, 0, 64'h0, 1, 1, 1, none());
    applyStimulus(0, 0, 0, 0, 64'h0, 1, 1, 0, none());

    // T3 faults and range boundaries
    applyStimulus(0, 0, 0, 1, 64'h6, 1, 1, 0, flt(64'h6, 4'd0));
    applyStimulus(0, 0, 0, 1, 64'h3FFC, 1, 1, 1, ok(64'h3FFC, IE));
    applyStimulus(0, 0, 0, 1, 64'h4000, 1, 1, 1, flt(64'h4000, 4'd1));
    applyStimulus(0, 0, 0, 1, 64'h4004, 1, 1, 1, flt(64'h4004, 4'd1));
    applyStimulus(0, 0, 0, 1, 64'h4002, 1, 1, 1, flt(64'h4002, 4'd0));
    applyStimulus(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1, 1,
                  flt(64'hFFFF_FFFF_FFFF_FFFC, 4'd1));
    applyStimulus(0, 0, 0, 0, 64'h0, 1, 1, 1, none());
    applyStimulus(0, 0, 0, 0, 64'h0, 1, 1, 0, none());
    checkOutput("T3 fault_count", 64'(fault_count0), 64'd5);

    // T5 flush with two entries buffered
    applyStimulus(0, 0, 0, 1, 64'h0, 0, 1, 0, ok(64'h0, IA));
    applyStimulus(0, 0, 0, 1, 64'h4, 0, 1, 1, ok(64'h4, IB));
    applyStimulus(0, 0, 1, 1, 64'h8, 1, 0, 1, none());
    applyStimulus(0, 0, 0, 0, 64'h0, 1, 1, 0, none());
    applyStimulus(0, 0, 0, 1, 64'hC, 1, 1, 0, ok(64'hC, ID));
    applyStimulus(0, 0, 0, 0, 64'h0, 1, 1, 1, none());
    applyStimulus(0, 0, 0, 0, 64'h0, 1, 1, 0, none());
    checkOutput("T5 fault_count kept", 64'(fault_count0), 64'd5);

    // T6 reset with a full FIFO and flush asserted
    applyStimulus(0, 0, 0, 1, 64'h6, 0, 1, 0, flt(64'h6, 4'd0));
    applyStimulus(0, 0, 0, 1, 64'h4, 0, 1, 1, ok(64'h4, IB));
    checkOutput("T6 fault_count before", 64'(fault_count0), 64'd6);
    applyStimulus(0, 1, 1, 1, 64'h8, 1, 0, 1, none());
    applyStimulus(0, 0, 0, 0, 64'h0, 1, 1, 0, none());
    checkOutput("T6 fault_count cleared", 64'(fault_count0), 64'd0);
    checkOutput("T6 rsp_instr", 64'(instr0), 64'(NOP));
    applyStimulus(0, 0, 0, 1, 64'h0, 1, 1, 0, ok(64'h0, IA));
    applyStimulus(0, 0, 0, 0, 64'h0, 1, 1, 1, none());
    applyStimulus(0, 0, 0, 0, 64'h0, 1, 1, 0, none());

    // T4 non-zero BASE_ADDR
    applyStimulus(1, 0, 0, 1, 64'h8000_0000, 1, 1, 0, ok(64'h8000_0000, IF1));
    applyStimulus(1, 0, 0, 1, 64'h7FFF_FFFC, 1, 1, 1, flt(64'h7FFF_FFFC, 4'd1));
    applyStimulus(1, 0, 0, 1, 64'h8000_4000, 1, 1, 1, flt(64'h8000_4000, 4'd1));
    applyStimulus(1, 0, 0, 1, 64'h8000_3FFC, 1, 1, 1, ok(64'h8000_3FFC, IG1));
    applyStimulus(1, 0, 0, 0, 64'h0, 1, 1, 1, none());
    applyStimulus(1, 0, 0, 0, 64'h0, 1, 1, 0, none());
    checkOutput("T4 fault_count", 64'(fault_count1), 64'd2);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("dut0 scoreboard drained", 64'(exp0.size()), 64'd0);
    checkOutput("dut1 scoreboard drained", 64'(exp1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
